// File: rtl/draw_pkg.sv
// Shared constants and types for the object draw engine: screen extent,
// sprite sizes and colours, request ids and FSM states.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [7:0] BG_W    = 8'd160;
    localparam logic [6:0] BG_H    = 7'd120;
    localparam logic [7:0] GOLD_W  = 8'd8;
    localparam logic [6:0] GOLD_H  = 7'd8;
    localparam logic [7:0] STONE_W = 8'd8;
    localparam logic [6:0] STONE_H = 7'd8;
    localparam logic [7:0] HOOK_W  = 8'd4;
    localparam logic [6:0] HOOK_H  = 7'd4;

    localparam logic [2:0] COL_BG    = 3'b000;
    localparam logic [2:0] COL_GOLD  = 3'b110;
    localparam logic [2:0] COL_STONE = 3'b011;
    localparam logic [2:0] COL_HOOK  = 3'b111;

    // Encoding doubles as the bit index of the matching done output.
    typedef enum logic [1:0] {
        REQ_BG    = 2'd0,
        REQ_GOLD  = 2'd1,
        REQ_STONE = 2'd2,
        REQ_HOOK  = 2'd3
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } draw_state_e;

endpackage

// File: rtl/draw_raster_counter.sv
// Raster offset generator: loads a sprite width/height, walks x fastest then y,
// and flags the final offset of the rectangle.
module draw_raster_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] off_x,
    output logic [6:0] off_y,
    output logic       last
);

    logic [7:0] off_x_q, off_x_d, w_q, w_d;
    logic [6:0] off_y_q, off_y_d, h_q, h_d;
    logic       x_end;

    assign x_end = (off_x_q == w_q - 8'd1);

    always_comb begin
        off_x_d = off_x_q;
        off_y_d = off_y_q;
        w_d     = w_q;
        h_d     = h_q;
        if (load) begin
            off_x_d = 8'd0;
            off_y_d = 7'd0;
            w_d     = width;
            h_d     = height;
        end else if (step) begin
            if (x_end) begin
                off_x_d = 8'd0;
                off_y_d = off_y_q + 7'd1;
            end else begin
                off_x_d = off_x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            off_x_q <= 8'd0;
            off_y_q <= 7'd0;
            w_q     <= 8'd0;
            h_q     <= 7'd0;
        end else begin
            off_x_q <= off_x_d;
            off_y_q <= off_y_d;
            w_q     <= w_d;
            h_q     <= h_d;
        end
    end

    assign off_x = off_x_q;
    assign off_y = off_y_q;
    assign last  = x_end && (off_y_q == h_q - 7'd1);

endmodule

// File: rtl/object_draw_engine.sv
// Sprite/background rasteriser feeding a VGA pixel-write port, one pixel per cycle.
// Define DRAW_CLIP_EN to suppress off-screen pixels; otherwise coordinates wrap.
//
// state      | meaning
// IDLE       | waiting for any enable; latches the highest-priority request
// SCAN       | emitting one pixel per cycle in raster order
// DONE       | one cycle; pulses the done output of the latched request
// RELEASE    | waiting for all enables low so a held request cannot retrigger
module object_draw_engine
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable_draw_background,
    input  logic       enable_draw_gold,
    input  logic       enable_draw_stone,
    input  logic       enable_draw_hook,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [7:0] hook_x,
    input  logic [6:0] hook_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       draw_background_done,
    output logic       draw_gold_done,
    output logic       draw_stone_done,
    output logic       draw_hook_done
);

    draw_state_e state_q, state_d;
    req_id_e     req_q, req_d, sel_req;
    logic [7:0]  org_x_q, org_x_d, sel_x, sel_w;
    logic [6:0]  org_y_q, org_y_d, sel_y, sel_h;
    logic [2:0]  col_q, col_d, sel_col;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;
    logic        plot_q, plot_d;
    logic [3:0]  done_q, done_d;

    logic        any_en, load, step, last;
    logic [7:0]  off_x;
    logic [6:0]  off_y;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic        transparent, visible;

    assign any_en = enable_draw_background | enable_draw_gold |
                    enable_draw_stone | enable_draw_hook;

    always_comb begin
        sel_req = REQ_HOOK;
        sel_x   = hook_x;
        sel_y   = hook_y;
        sel_w   = HOOK_W;
        sel_h   = HOOK_H;
        sel_col = COL_HOOK;
        if (enable_draw_background) begin
            sel_req = REQ_BG;
            sel_x   = 8'd0;
            sel_y   = 7'd0;
            sel_w   = BG_W;
            sel_h   = BG_H;
            sel_col = COL_BG;
        end else if (enable_draw_gold) begin
            sel_req = REQ_GOLD;
            sel_x   = obj_x;
            sel_y   = obj_y;
            sel_w   = GOLD_W;
            sel_h   = GOLD_H;
            sel_col = COL_GOLD;
        end else if (enable_draw_stone) begin
            sel_req = REQ_STONE;
            sel_x   = obj_x;
            sel_y   = obj_y;
            sel_w   = STONE_W;
            sel_h   = STONE_H;
            sel_col = COL_STONE;
        end
    end

    draw_raster_counter u_raster (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .width  (sel_w),
        .height (sel_h),
        .off_x  (off_x),
        .off_y  (off_y),
        .last   (last)
    );

    assign px_x = {1'b0, org_x_q} + {1'b0, off_x};
    assign px_y = {1'b0, org_y_q} + {1'b0, off_y};

    assign transparent = (req_q == REQ_GOLD) &&
                         ((off_x == 8'd0) || (off_x == GOLD_W - 8'd1)) &&
                         ((off_y == 7'd0) || (off_y == GOLD_H - 7'd1));

`ifdef DRAW_CLIP_EN
    assign visible = !transparent && (px_x < 9'(SCREEN_W)) && (px_y < 8'(SCREEN_H));
`else
    // Wrapping build: the carry bits are dropped on purpose.
    logic unused_coord_msb;
    assign unused_coord_msb = px_x[8] ^ px_y[7];
    assign visible = !transparent;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        org_x_d      = org_x_q;
        org_y_d      = org_y_q;
        col_d        = col_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        plot_d       = 1'b0;
        done_d       = 4'b0000;
        load         = 1'b0;
        step         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_en) begin
                    load    = 1'b1;
                    req_d   = sel_req;
                    org_x_d = sel_x;
                    org_y_d = sel_y;
                    col_d   = sel_col;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                step         = 1'b1;
                vga_x_d      = px_x[7:0];
                vga_y_d      = px_y[6:0];
                vga_colour_d = col_q;
                plot_d       = visible;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 4'b0001 << req_q;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!any_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            req_q        <= REQ_BG;
            org_x_q      <= 8'd0;
            org_y_q      <= 7'd0;
            col_q        <= 3'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            plot_q       <= 1'b0;
            done_q       <= 4'b0000;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            org_x_q      <= org_x_d;
            org_y_q      <= org_y_d;
            col_q        <= col_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
        end
    end

    assign vga_x                = vga_x_q;
    assign vga_y                = vga_y_q;
    assign vga_colour           = vga_colour_q;
    assign plot                 = plot_q;
    assign draw_background_done = done_q[REQ_BG];
    assign draw_gold_done       = done_q[REQ_GOLD];
    assign draw_stone_done      = done_q[REQ_STONE];
    assign draw_hook_done       = done_q[REQ_HOOK];

endmodule

// File: tb/tb_object_draw_engine.sv
// Self-checking bench for object_draw_engine: directed scenarios plus random
// sprite requests compared against a rectangle-walk reference model.
module tb_object_draw_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en_bg, en_gold, en_stone, en_hook;
    logic [7:0] obj_x, hook_x;
    logic [6:0] obj_y, hook_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       bg_done, gold_done, stone_done, hook_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    object_draw_engine dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .enable_draw_background (en_bg),
        .enable_draw_gold       (en_gold),
        .enable_draw_stone      (en_stone),
        .enable_draw_hook       (en_hook),
        .obj_x                  (obj_x),
        .obj_y                  (obj_y),
        .hook_x                 (hook_x),
        .hook_y                 (hook_y),
        .vga_x                  (vga_x),
        .vga_y                  (vga_y),
        .vga_colour             (vga_colour),
        .plot                   (plot),
        .draw_background_done   (bg_done),
        .draw_gold_done         (gold_done),
        .draw_stone_done        (stone_done),
        .draw_hook_done         (hook_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dones();
        return {bg_done, gold_done, stone_done, hook_done};
    endfunction

    task automatic set_en(input logic [3:0] en);
        {en_bg, en_gold, en_stone, en_hook} = en;
    endtask

    // en = {background, gold, stone, hook}. Called #1 after an edge with the DUT idle.
    task automatic run_draw(input logic [3:0] en, input logic [7:0] ox, input logic [6:0] oy,
                            input logic [7:0] hx, input logic [6:0] hy,
                            input int hold, input bit wiggle,
                            output int n_plot, output int fx, output int fy,
                            output int lx, output int ly);
        int w, h, bx, by, col, dx, dy, px, py;
        bit is_gold, corner, exp_plot;
        logic [3:0] exp_done;
        if (en[3]) begin
            w = 160; h = 120; bx = 0; by = 0; col = 0; exp_done = 4'b1000; is_gold = 0;
        end else if (en[2]) begin
            w = 8; h = 8; bx = ox; by = oy; col = 6; exp_done = 4'b0100; is_gold = 1;
        end else if (en[1]) begin
            w = 8; h = 8; bx = ox; by = oy; col = 3; exp_done = 4'b0010; is_gold = 0;
        end else begin
            w = 4; h = 4; bx = hx; by = hy; col = 7; exp_done = 4'b0001; is_gold = 0;
        end
        n_plot = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        obj_x = ox; obj_y = oy; hook_x = hx; hook_y = hy;
        set_en(en);
        @(posedge clk); #1;
        for (int i = 0; i < w * h; i++) begin
            @(posedge clk); #1;
            if (wiggle && i == 3) begin
                obj_x  = obj_x + 8'd37;
                obj_y  = obj_y + 7'd11;
                hook_x = hook_x + 8'd53;
                hook_y = hook_y + 7'd9;
            end
            dx = i % w;
            dy = i / w;
            px = bx + dx;
            py = by + dy;
            corner = is_gold && (dx == 0 || dx == w - 1) && (dy == 0 || dy == h - 1);
`ifdef DRAW_CLIP_EN
            exp_plot = !corner && px < 160 && py < 120;
`else
            exp_plot = !corner;
`endif
            check("scan_plot", plot, exp_plot);
            check("scan_x", vga_x, px % 256);
            check("scan_y", vga_y, py % 128);
            check("scan_colour", vga_colour, col);
            check("scan_done", dones(), 0);
            if (plot === 1'b1) begin
                n_plot++;
                if (fx < 0) begin fx = vga_x; fy = vga_y; end
                lx = vga_x; ly = vga_y;
            end
        end
        @(posedge clk); #1;
        check("done_pulse", dones(), exp_done);
        check("done_plot", plot, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_plot", plot, 0);
            check("hold_done", dones(), 0);
        end
        set_en(4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rel_plot", plot, 0);
            check("rel_done", dones(), 0);
        end
    endtask

    initial begin
        int np, fx, fy, lx, ly;
        int r;
        logic [3:0] en;

        resetn = 1'b0;
        set_en(4'b0000);
        obj_x = 0; obj_y = 0; hook_x = 0; hook_y = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        check("rst_plot", plot, 0);
        check("rst_done", dones(), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Gold held high for a while: transparent corners, no retrigger.
        run_draw(4'b0100, 8'd10, 7'd20, 8'd0, 7'd0, 6, 1'b0, np, fx, fy, lx, ly);
        check("gold_nplot", np, 60);
        check("gold_first_x", fx, 11);
        check("gold_first_y", fy, 20);
        check("gold_last_x", lx, 16);
        check("gold_last_y", ly, 27);

        // Background and hook together: background wins, then hook on re-request.
        run_draw(4'b1001, 8'd0, 7'd0, 8'd30, 7'd40, 3, 1'b0, np, fx, fy, lx, ly);
        check("bg_nplot", np, 19200);
        run_draw(4'b0001, 8'd0, 7'd0, 8'd30, 7'd40, 0, 1'b0, np, fx, fy, lx, ly);
        check("hook_nplot", np, 16);

        // Stone straddling the bottom-right corner.
        run_draw(4'b0010, 8'd156, 7'd118, 8'd0, 7'd0, 0, 1'b0, np, fx, fy, lx, ly);
`ifdef DRAW_CLIP_EN
        check("stone_edge_nplot", np, 8);
`else
        check("stone_edge_nplot", np, 64);
`endif

        // Origin inputs changed mid-scan must not move the sprite.
        run_draw(4'b0100, 8'd70, 7'd33, 8'd0, 7'd0, 1, 1'b1, np, fx, fy, lx, ly);
        check("wiggle_first_x", fx, 71);
        run_draw(4'b0001, 8'd0, 7'd0, 8'd250, 7'd125, 0, 1'b1, np, fx, fy, lx, ly);

        // Reset in the middle of a gold scan.
        obj_x = 8'd40; obj_y = 7'd50;
        set_en(4'b0100);
        @(posedge clk); #1;
        repeat (30) @(posedge clk);
        #1;
        check("mid_scan_plot", plot, 1);
        resetn = 1'b0;
        set_en(4'b0000);
        @(posedge clk); #1;
        check("abort_x", vga_x, 0);
        check("abort_y", vga_y, 0);
        check("abort_colour", vga_colour, 0);
        check("abort_plot", plot, 0);
        check("abort_done", dones(), 0);
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_plot", plot, 0);
            check("post_rst_done", dones(), 0);
        end
        run_draw(4'b0010, 8'd5, 7'd6, 8'd0, 7'd0, 0, 1'b0, np, fx, fy, lx, ly);
        check("post_rst_nplot", np, 64);

        // Random sprite requests with random origins, holds and mid-scan changes.
        for (int k = 0; k < 16; k++) begin
            r  = $urandom_range(1, 7);
            en = {1'b0, 3'(r)};
            run_draw(en, 8'($urandom), 7'($urandom), 8'($urandom), 7'($urandom),
                     $urandom_range(0, 3), 1'($urandom), np, fx, fy, lx, ly);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
